// File: rtl/pll_reset_ctrl_pkg.sv
// Shared clocking definitions: reset-sequencer states and default timing constants
// for the PLL reset controller and the board top levels that instantiate it.
package pll_reset_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } pll_state_e;

  // Defaults assume a 50 MHz reference clock.
  localparam int DEF_RST_PULSE     = 16;
  localparam int DEF_LOCK_TIMEOUT  = 500000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES   = 64;

  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single level signal crossing into clk.
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases the
// system reset; recovers from lock loss and services debug soft resets.
module pll_reset_ctrl
  import pll_reset_ctrl_pkg::*;
#(
  parameter int RST_PULSE     = DEF_RST_PULSE,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       running,
  output logic [7:0] relock_count
);

  localparam int CNT_W = $clog2(max4(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES, HOLD_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  pll_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;
  logic             relock_hit;

  bit_sync u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nxt  = state;
    relock_hit = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s)               state_nxt = ST_STABLE;
        else if (cnt == LOCK_LAST)  state_nxt = ST_PLL_RST;
      end
      // A glitch here only restarts qualification; the PLL is not reset again.
      ST_STABLE: begin
        if (!locked_s)               state_nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!locked_s)             state_nxt = ST_PLL_RST;
        else if (cnt == HOLD_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_nxt  = ST_PLL_RST;
          relock_hit = 1'b1;
        end else if (soft_reset_req) begin
          state_nxt  = ST_HOLD;
        end
      end
      default: state_nxt = ST_PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_PLL_RST;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_reset    <= 1'b1;
      running      <= 1'b0;
      relock_count <= '0;
    end else begin
      state     <= state_nxt;
      pll_rst   <= (state_nxt == ST_PLL_RST);
      sys_reset <= (state_nxt != ST_RUN);
      running   <= (state_nxt == ST_RUN);
      if (state_nxt != state)
        cnt <= '0;
      else if (cnt != CNT_SAT)
        cnt <= cnt + 1'b1;
      if (relock_hit && relock_count != RELOCK_MAX)
        relock_count <= relock_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against a countdown-based reference model.
module tb_pll_reset_ctrl;

  localparam int RP = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int HC = 4;

  logic       clk = 1'b0;
  logic       reset, pll_locked, soft_reset_req;
  logic       pll_rst, sys_reset, running;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_reset_ctrl #(
    .RST_PULSE     (RP),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .HOLD_CYCLES   (HC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_reset      (sys_reset),
    .running        (running),
    .relock_count   (relock_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return {pll_rst, sys_reset, running, relock_count};
  endfunction

  // Reference model: phase plus cycles left in it, lock seen through a 2-deep history.
  localparam int M_RST = 10, M_WAIT = 11, M_STAB = 12, M_HOLD = 13, M_RUN = 14;
  int m_ph, m_left, m_rc;
  bit h0, h1;

  function automatic int dur(input int ph);
    case (ph)
      M_RST:   return RP;
      M_WAIT:  return LT;
      M_STAB:  return SC;
      M_HOLD:  return HC;
      default: return 0;
    endcase
  endfunction

  task automatic enter(input int ph);
    m_ph   = ph;
    m_left = dur(ph);
  endtask

  task automatic model_step(input bit r, input bit d, input bit sr);
    bit ls;
    if (r) begin
      enter(M_RST);
      h0 = 0; h1 = 0; m_rc = 0;
      return;
    end
    ls = h1; h1 = h0; h0 = d;
    case (m_ph)
      M_RST:  if (m_left == 1) enter(M_WAIT); else m_left--;
      M_WAIT: if (ls) enter(M_STAB); else if (m_left == 1) enter(M_RST); else m_left--;
      M_STAB: if (!ls) enter(M_WAIT); else if (m_left == 1) enter(M_HOLD); else m_left--;
      M_HOLD: if (!ls) enter(M_RST); else if (m_left == 1) enter(M_RUN); else m_left--;
      default: begin
        if (!ls) begin
          if (m_rc < 255) m_rc++;
          enter(M_RST);
        end else if (sr) enter(M_HOLD);
      end
    endcase
  endtask

  function automatic logic [10:0] model_outs();
    return {m_ph == M_RST, m_ph != M_RUN, m_ph == M_RUN, 8'(m_rc)};
  endfunction

  task automatic do_reset();
    reset = 1; soft_reset_req = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic wait_run(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (running) begin ok = 1; break; end
    end
  endtask

  // Ticks from the first edge that samples pll_locked=1 until sys_reset drops.
  task automatic measure_release(input string name, output bit saw_prst);
    int fall;
    fall = -1; saw_prst = 0;
    pll_locked = 1;
    for (int i = 0; i <= 40; i++) begin
      tick();
      if (pll_rst) saw_prst = 1;
      if (!sys_reset) begin fall = i; break; end
    end
    chk(name, fall, 14);
  endtask

  typedef struct {
    logic       rst, lck, srq;
    int         n;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok, saw;
    int rises[$];
    int first_fall, hi_len, runlen;
    bit prev, sys_low, lvl;

    reset = 1; pll_locked = 0; soft_reset_req = 0;

    //             rst lck srq  n   {prst,sys,run,rc}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2,  {3'b110, 8'd0}};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 3,  {3'b110, 8'd0}};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1,  {3'b010, 8'd0}};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 6,  {3'b010, 8'd0}};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 14, {3'b010, 8'd0}};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1,  {3'b001, 8'd0}};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1,  {3'b010, 8'd0}};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 3,  {3'b010, 8'd0}};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1,  {3'b001, 8'd0}};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2,  {3'b001, 8'd0}};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1,  {3'b110, 8'd1}};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 3,  {3'b110, 8'd1}};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1,  {3'b010, 8'd1}};

    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst; pll_locked = tbl[i].lck; soft_reset_req = tbl[i].srq;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        soft_reset_req = 0;
      end
      chk($sformatf("tbl%0d", i), outs(), tbl[i].exp);
    end

    // No lock ever: periodic PLL reset pulses, system stays in reset.
    pll_locked = 0;
    do_reset();
    first_fall = -1; hi_len = 0; prev = 1; sys_low = 0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (!sys_reset) sys_low = 1;
      if (pll_rst && !prev) begin rises.push_back(i); hi_len = 0; end
      if (pll_rst) hi_len++;
      if (!pll_rst && prev) begin
        if (first_fall < 0) first_fall = i;
        else chk("pulse_len", hi_len, RP);
      end
      prev = pll_rst;
    end
    chk("first_fall", first_fall, RP);
    chk("num_pulses", rises.size(), 4);
    foreach (rises[k]) chk($sformatf("pulse_rise%0d", k), rises[k], (k + 1) * (RP + LT));
    chk("nolock_sys", sys_low, 0);

    // One-cycle lock glitch during qualification.
    pll_locked = 1;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    pll_locked = 0;
    tick();
    measure_release("glitch_release", saw);
    chk("glitch_no_prst", saw, 0);

    // Soft reset request while waiting for lock is ignored.
    pll_locked = 0;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    soft_reset_req = 1;
    tick();
    soft_reset_req = 0;
    chk("wait_soft_outs", outs(), {3'b010, 8'd0});
    measure_release("wait_soft_release", saw);

    // Reset in HOLD with relock_count=3.
    pll_locked = 1;
    do_reset();
    wait_run(ok);
    chk("run_reached", ok, 1);
    for (int d = 0; d < 3; d++) begin
      pll_locked = 0;
      tick(); tick(); tick();
      pll_locked = 1;
      wait_run(ok);
      chk($sformatf("relock_run%0d", d), ok, 1);
    end
    chk("relock3", relock_count, 3);
    soft_reset_req = 1;
    tick();
    soft_reset_req = 0;
    chk("hold_outs", outs(), {3'b010, 8'd3});
    reset = 1;
    tick();
    reset = 0;
    chk("reset_in_hold", outs(), {3'b110, 8'd0});

    // Saturation of relock_count.
    wait_run(ok);
    for (int d = 1; d <= 300 && ok; d++) begin
      pll_locked = 0;
      tick(); tick(); tick();
      pll_locked = 1;
      wait_run(ok);
      if (d == 10) chk("relock10", relock_count, 10);
    end
    chk("sat_run_ok", ok, 1);
    chk("relock_sat", relock_count, 255);

    // Randomized traffic against the reference model.
    pll_locked = 0; soft_reset_req = 0; reset = 1;
    tick(); model_step(1, 0, 0);
    runlen = 0; lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if (runlen == 0) begin
        lvl = ($urandom_range(0, 3) != 0);
        if (lvl) runlen = $urandom_range(10, 150);
        else if ($urandom_range(0, 4) == 0) runlen = $urandom_range(30, 60);
        else runlen = $urandom_range(1, 4);
      end
      runlen--;
      pll_locked     = lvl;
      soft_reset_req = ($urandom_range(0, 11) == 0);
      reset          = ($urandom_range(0, 699) == 0);
      tick();
      model_step(reset, pll_locked, soft_reset_req);
      chk($sformatf("rand%0d", i), outs(), model_outs());
    end
    reset = 0; soft_reset_req = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL have parameter RST_PULSE, default 16: PLL reset pulse length in clk cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 500000: cycles to wait for lock before re-pulsing the PLL reset (10 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before the block leaves lock qualification.
REQ-004 SHALL have parameter HOLD_CYCLES, default 64: cycles sys_reset is held after lock qualification or a soft reset.
REQ-005 SHALL have port clk, input, 1 bit: free-running 50 MHz board reference clock, the same clock that feeds the PLL refclk.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL locked flag, asynchronous to clk.
REQ-008 SHALL have port soft_reset_req, input, 1 bit: single-cycle system reset request from debug logic.
REQ-009 SHALL have port pll_rst, output, 1 bit: drives the PLL rst input.
REQ-010 SHALL have port sys_reset, output, 1 bit: system reset level; each PLL clock domain synchronizes it locally.
REQ-011 SHALL have port running, output, 1 bit: high only in RUN.
REQ-012 SHALL have port relock_count, output, 8 bits: count of lock losses seen in RUN, saturating.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer; locked_s lags pll_locked by 2 cycles.
REQ-014 SHALL implement the states PLL_RST, WAIT_LOCK, STABLE, HOLD and RUN, using one shared cycle counter that clears on every state change.
REQ-015 PLL_RST: pll_rst=1 for exactly RST_PULSE cycles, then go to WAIT_LOCK.
REQ-016 WAIT_LOCK: if locked_s=1, go to STABLE; else after LOCK_TIMEOUT cycles, go to PLL_RST.
REQ-017 STABLE: if locked_s=0 on any cycle, go to WAIT_LOCK (no PLL reset); after STABLE_CYCLES consecutive high cycles, go to HOLD.
REQ-018 HOLD: stay exactly HOLD_CYCLES cycles, then go to RUN; a locked_s drop in HOLD goes to PLL_RST and does not increment relock_count.
REQ-019 RUN: if locked_s=0, go to PLL_RST and increment relock_count, saturating at 255; otherwise a soft_reset_req goes to HOLD and leaves the PLL untouched.
REQ-020 SHALL ignore soft_reset_req outside RUN; in RUN, a lock loss takes priority over soft_reset_req.
REQ-021 sys_reset SHALL be 0 only in RUN; pll_rst SHALL be 1 only in PLL_RST.
REQ-022 All outputs SHALL be registered, glitch-free, and consistent with the state register in the same cycle.
REQ-023 The counter SHALL be $clog2 of the largest parameter plus 1 bit wide, and SHALL never wrap within a state.

Reset
REQ-024 reset SHALL force PLL_RST from any state, including mid-operation, on the next edge, with priority over every other input.
REQ-025 Reset values SHALL be: counter=0, pll_rst=1, sys_reset=1, running=0, relock_count=0, synchronizer flops=0.
REQ-026 PLL_RST SHALL hold while reset=1; the RST_PULSE count SHALL start on the first cycle with reset=0.

Structure
REQ-027 The state enumeration and the default timing constants SHALL live in the shared clocking package, for reuse by the board top levels.
REQ-028 SHALL instantiate one sub-module, bit_sync (a 2-flop synchronizer), for pll_locked; all other logic SHALL be inline.

Verification (bench params: RST_PULSE=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, HOLD_CYCLES=4)
REQ-029 Release reset, raise pll_locked 10 cycles later -> pll_rst high for exactly the first 4 cycles; sys_reset falls exactly 14 cycles (2+8+4) after pll_locked rises; running=1.
REQ-030 pll_locked held 0 -> pll_rst pulses 4 cycles high every 36 cycles indefinitely; sys_reset stays 1.
REQ-031 pll_locked low for 1 cycle in STABLE -> return to WAIT_LOCK, no pll_rst pulse, stable count restarts, sys_reset falls 14 cycles after the relock.
REQ-032 pll_locked drops in RUN -> sys_reset=1 within 3 cycles, one 4-cycle pll_rst pulse, relock_count=1; 300 such drops -> relock_count=255.
REQ-033 soft_reset_req pulsed in RUN -> sys_reset high exactly 4 cycles; pll_rst stays 0; relock_count unchanged; the same pulse in WAIT_LOCK has no effect.
REQ-034 reset asserted during HOLD with relock_count=3 -> next cycle pll_rst=1, sys_reset=1, running=0, relock_count=0.
